// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: drives the I-Memory read handshake and buffers fetched
// words with their PCs in a DEPTH-entry FIFO, with redirect flush and stale-data drain.
module fetch_prefetch_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PC_INIT = 0,
    parameter int PC_INCR = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       InstrMemAck,
    input  logic [DATA_W-1:0]          Instruction,
    output logic [ADDR_W-1:0]          PCForInstrMem,
    output logic                       InstrMemReadEnable,
    input  logic                       Redirect,
    input  logic [ADDR_W-1:0]          RedirectPC,
    input  logic                       Consume,
    output logic                       Valid,
    output logic [DATA_W-1:0]          InstrOut,
    output logic [ADDR_W-1:0]          PCOut,
    output logic                       IF_Stall,
    output logic [$clog2(DEPTH+1)-1:0] Count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q [DEPTH];
    logic              push;
    logic              pop;
    logic              space;

    // Queue bookkeeping; a redirect wins over both push and pop.
    always_comb begin
        push     = (state_q == REQ) && InstrMemAck && !Redirect;
        pop      = Consume && (count_q != '0) && !Redirect;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        if (Redirect) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        end
        // Space is judged on the post-update occupancy so a new request always has a slot.
        space = (count_d < CNT_W'(DEPTH));
    end

    always_comb begin
        state_d   = state_q;
        req_pc_d  = req_pc_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            IDLE: begin
                if (Redirect) begin
                    req_pc_d = RedirectPC;
                end else if (space) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (Redirect) begin
                    if (InstrMemAck) begin
                        req_pc_d = RedirectPC;
                        state_d  = REQ;
                    end else begin
                        pend_pc_d = RedirectPC;
                        state_d   = DRAIN;
                    end
                end else if (InstrMemAck) begin
                    req_pc_d = req_pc_q + ADDR_W'(PC_INCR);
                    state_d  = space ? REQ : IDLE;
                end
            end
            DRAIN: begin
                // The in-flight word belongs to the old path; its data is dropped on Ack.
                if (InstrMemAck) begin
                    req_pc_d = Redirect ? RedirectPC : pend_pc_q;
                    state_d  = REQ;
                end else if (Redirect) begin
                    pend_pc_d = RedirectPC;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= IDLE;
            req_pc_q  <= ADDR_W'(PC_INIT);
            pend_pc_q <= ADDR_W'(PC_INIT);
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_pc_q  <= req_pc_d;
            pend_pc_q <= pend_pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= Instruction;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

    assign PCForInstrMem      = req_pc_q;
    assign InstrMemReadEnable = (state_q != IDLE);
    assign Valid              = (count_q != '0);
    assign IF_Stall           = (count_q == '0);
    assign InstrOut           = (count_q != '0) ? instr_mem_q[rd_ptr_q] : '0;
    assign PCOut              = pc_mem_q[rd_ptr_q];
    assign Count              = count_q;

endmodule
